// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - shared state encoding and default sizing for the data-memory arbiter
package dm_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam int DM_ADDR_W   = 8;
  localparam int DM_DATA_W   = 8;
  localparam int DM_MAX_HOLD = 15;

endpackage

// File: rtl/dm_arb_hold_cnt.sv
// rtl/dm_arb_hold_cnt.sv - counts consecutive locked grants and flags when the owner must yield
module dm_arb_hold_cnt
  import dm_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = DM_MAX_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic limit_o
);

  localparam int CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !limit_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_o = (cnt_q == CW'(MAX_HOLD));

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port data-memory arbiter with lock ownership and hold limit
// DM_ARB_RR_EN selects round-robin instead of fixed port-0 priority for idle contention.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DM_ADDR_W,
  parameter int DATA_W   = DM_DATA_W,
  parameter int MAX_HOLD = DM_MAX_HOLD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rvalid0_q, rvalid1_q;
  logic              owner_req, owner_lock, other_req;
  logic              hold_limit, preempt, hold_clr, hold_inc;
  logic              gnt0_c, gnt1_c;
  logic              rr_prio;

`ifdef DM_ARB_RR_EN
  logic rr_q;
  assign rr_prio = rr_q;
`else
  assign rr_prio = 1'b0;
`endif

  always_comb begin
    owner_req  = 1'b0;
    owner_lock = 1'b0;
    other_req  = 1'b0;
    case (state_q)
      ST_OWN0: begin owner_req = req0; owner_lock = lock0; other_req = req1; end
      ST_OWN1: begin owner_req = req1; owner_lock = lock1; other_req = req0; end
      default: ;
    endcase
  end

  // Preemption steals a single cycle; ownership stays put so the owner resumes next cycle.
  assign preempt = owner_req & other_req & hold_limit;

  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!rst) begin
      if (owner_req) begin
        if (state_q == ST_OWN0) begin
          gnt0_c = ~preempt;
          gnt1_c = preempt;
        end else begin
          gnt1_c = ~preempt;
          gnt0_c = preempt;
        end
      end else if (req0 && req1) begin
        gnt1_c = rr_prio;
        gnt0_c = ~rr_prio;
      end else begin
        gnt0_c = req0;
        gnt1_c = req1;
      end
    end
  end

  always_comb begin
    if (owner_req && owner_lock) begin
      state_d = state_q;
    end else if (gnt0_c && lock0) begin
      state_d = ST_OWN0;
    end else if (gnt1_c && lock1) begin
      state_d = ST_OWN1;
    end else begin
      state_d = ST_IDLE;
    end
  end

  assign hold_inc = owner_req & other_req & ~preempt;
  assign hold_clr = ~other_req | preempt | (state_d != state_q);

  dm_arb_hold_cnt #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (hold_clr),
    .inc_i   (hold_inc),
    .limit_o (hold_limit)
  );

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (gnt0_c) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1_c) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
`ifdef DM_ARB_RR_EN
      rr_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rvalid0_q <= gnt0_c & ~we0;
      rvalid1_q <= gnt1_c & ~we1;
      if (gnt0_c || gnt1_c) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
`ifdef DM_ARB_RR_EN
      if (gnt0_c) begin
        rr_q <= 1'b1;
      end else if (gnt1_c) begin
        rr_q <= 1'b0;
      end
`endif
    end
  end

  // Masking with rst drops a read response that would otherwise land in the reset cycle.
  assign rvalid0 = rvalid0_q & ~rst;
  assign rvalid1 = rvalid1_q & ~rst;
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;
  assign gnt0    = gnt0_c;
  assign gnt1    = gnt1_c;

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter ADDR_W, 8, data-memory address width.
REQ-002 Parameter DATA_W, 8, data-memory data width.
REQ-003 Parameter MAX_HOLD, 15, maximum consecutive locked grants while the other requester waits.
REQ-004 Port clk  input  1  single clock, all logic on rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Ports req0/req1  input  1  access request, port 0 = CPU, port 1 = I/O loader.
REQ-007 Ports we0/we1  input  1  1 = write, 0 = read, qualified by reqN.
REQ-008 Ports addr0/addr1  input  ADDR_W  request address.
REQ-009 Ports wdata0/wdata1  input  DATA_W  write data.
REQ-010 Ports lock0/lock1  input  1  keep ownership across consecutive cycles.
REQ-011 Ports gnt0/gnt1  output  1  request accepted this cycle (combinational from state and inputs).
REQ-012 Ports rvalid0/rvalid1  output  1  read data valid, one cycle after a granted read.
REQ-013 Ports rdata0/rdata1  output  DATA_W  read data, broadcast from mem_rdata.
REQ-014 Ports mem_addr/mem_wdata  output  ADDR_W/DATA_W  driven to data memory.
REQ-015 Port mem_we  output  1  data-memory write enable.
REQ-016 Port mem_rdata  input  DATA_W  data-memory output, valid the cycle after the address is presented.

Function
REQ-017 The arbiter SHALL grant at most one port per cycle; gnt0 and gnt1 never both high.
REQ-018 States: IDLE (no owner), OWN0, OWN1; the state holds the port owning the memory under lock.
REQ-019 In IDLE, a single request SHALL be granted in the same cycle; with both requesting, the winner is set by the policy in REQ-031/032.
REQ-020 A granted request with lockN=1 SHALL move to OWNn; with lockN=0, the arbiter returns to or stays in IDLE.
REQ-021 In OWNn, port n SHALL win every cycle it requests; the state returns to IDLE when reqn=0 or lockn=0.
REQ-022 A hold counter SHALL count consecutive granted cycles in OWNn while the other port requests; at MAX_HOLD the owner SHALL lose the next cycle, the other port is granted and the counter clears.
REQ-023 The hold counter SHALL clear whenever the other port is not requesting or the state changes.
REQ-024 mem_addr, mem_wdata and mem_we SHALL reflect the granted port combinationally; with no grant, mem_we=0 and mem_addr holds its last value.
REQ-025 A granted read SHALL assert rvalidN exactly one cycle later for the same port; writes SHALL never assert rvalid.
REQ-026 Back-to-back granted reads SHALL produce back-to-back rvalid pulses in order, with no bubbles.
REQ-027 An ungranted request SHALL have no side effect; the requester holds req, we, addr and wdata stable until granted.

Reset
REQ-028 On rst=1 at a clock edge: state=IDLE, hold counter=0, rvalid0=rvalid1=0, round-robin pointer=port 0, mem_we=0, mem_addr=0.
REQ-029 During rst, gnt0=gnt1=0 regardless of requests.
REQ-030 A read granted in the cycle before reset SHALL NOT produce rvalid after reset.

Configuration
REQ-031 With DM_ARB_RR_EN defined, IDLE contention SHALL be resolved round-robin: the port not granted last wins, and the pointer updates on every grant.
REQ-032 Without DM_ARB_RR_EN, IDLE contention SHALL always grant port 0. The pointer SHALL be absent; REQ-022 still applies.

Structure
REQ-033 A shared package SHALL hold the state enumeration (IDLE/OWN0/OWN1) and the default widths and MAX_HOLD constants.
REQ-034 The hold counter SHALL be a sub-module, dm_arb_hold_cnt, with clear, increment and limit-reached ports.

Verification
REQ-035 Only req0 active, read from 0x10 with memory holding 0xA5 -> gnt0 in the same cycle, rvalid0=1 with rdata0=0xA5 in the next cycle, rvalid1=0.
REQ-036 req0 and req1 both write, in IDLE, for 4 cycles -> with RR_EN grants alternate 0,1,0,1; without it gnt0 is high every cycle.
REQ-037 Port 1 locked burst with req0 held, MAX_HOLD=15 -> 15 consecutive gnt1, then gnt0 for one cycle, then port 1 resumes.
REQ-038 Reads from port 0 to 0x00, 0x01, 0x02 on consecutive cycles -> three consecutive rvalid0 pulses carrying the matching data in order.
REQ-039 Reset asserted in OWN1 while a read is granted -> no rvalid1 after reset, state IDLE, next single req0 granted immediately.
REQ-040 Write 0x3C to 0x20 from port 1, then read 0x20 from port 0 -> rdata0=0x3C with rvalid0.
